// File: rtl/vga_timing_pkg.sv
// Shared 640x480 raster constants and RGB565 field positions.
// No logic; parameters only.
// Used as defaults by the timing generator and the framebuffer reader.
package vga_timing_pkg;

  // 640x480 @ 60 Hz horizontal timing, in pixel clocks
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // 640x480 @ 60 Hz vertical timing, in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // RGB565 field slices
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // Pure green marks pixels that pass the colour threshold
  localparam logic [15:0] HIGHLIGHT_DEFAULT = 16'h07E0;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster h/v counters with combinational active/hsync/vsync decode.
// Latency: decode is combinational from the current counter values.
// No backpressure: free-running at the pixel clock.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hsync,
  output logic          vsync
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Advance the raster one pixel; v steps when h wraps
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hsync  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vsync  = !((v_cnt >= VS_START) && (v_cnt < VS_END));

endmodule

// File: rtl/fbuf_display_reader.sv
// Framebuffer scan-out to VGA with per-pixel colour-threshold detect and match count.
// Latency: sync/DE/RGB appear 3 clk after their raster position; read address 1 clk.
// No backpressure: raster is free-running, framebuffer read data assumed 1 clk after address.
module fbuf_display_reader
  import vga_timing_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_W    = 320,
  parameter int FRAME_H    = 240,
  parameter int BRAM_DEPTH = 76800,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter logic [DATA_WIDTH-1:0] HIGHLIGHT = HIGHLIGHT_DEFAULT
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  output logic [$clog2(BRAM_DEPTH)-1:0]     o_raddr,
  input  logic [DATA_WIDTH-1:0]             i_rdata,
  input  logic                              i_detect_en,
  input  logic                              i_highlight,
  input  logic [4:0]                        i_r_min,
  input  logic [5:0]                        i_g_max,
  input  logic [4:0]                        i_b_max,
  output logic                              o_hsync,
  output logic                              o_vsync,
  output logic                              o_de,
  output logic [DATA_WIDTH-1:0]             o_rgb,
  output logic [$clog2(BRAM_DEPTH+1)-1:0]   o_match_count,
  output logic                              o_frame_done
);

  localparam int AW      = $clog2(BRAM_DEPTH);
  localparam int CW      = $clog2(BRAM_DEPTH + 1);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] FW_C    = HW'(FRAME_W);
  localparam logic [VW-1:0] FH_C    = VW'(FRAME_H);
  localparam logic [HW-1:0] FW_LAST = HW'(FRAME_W - 1);
  localparam logic [VW-1:0] FH_LAST = VW'(FRAME_H - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BRAM_DEPTH);

  // The window must sit inside the visible area and match the buffer size
  if (FRAME_W > H_ACTIVE || FRAME_H > V_ACTIVE) begin : g_bad_window
    $error("fbuf_display_reader: window %0dx%0d exceeds active area", FRAME_W, FRAME_H);
  end
  if (BRAM_DEPTH != FRAME_W * FRAME_H) begin : g_bad_depth
    $error("fbuf_display_reader: BRAM_DEPTH must equal FRAME_W*FRAME_H");
  end
  if (DATA_WIDTH != 16) begin : g_bad_width
    $error("fbuf_display_reader: detector needs RGB565 (DATA_WIDTH=16)");
  end

  // Stage 0: raster position and decode
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          act0, hs0, vs0, win0, last0, frame_end0;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .active (act0),
    .hsync  (hs0),
    .vsync  (vs0)
  );

  assign win0       = (h_cnt < FW_C) && (v_cnt < FH_C);
  assign last0      = (h_cnt == FW_LAST) && (v_cnt == FH_LAST);
  assign frame_end0 = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  logic [AW-1:0] addr_cnt;
  logic          act1, hs1, vs1, win1, last1;
  logic          act2, hs2, vs2, win2, last2;

  // Stage 1: issue the read address for window pixels and carry the raster flags
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_raddr  <= '0;
      addr_cnt <= '0;
      act1     <= 1'b0;
      hs1      <= 1'b1;
      vs1      <= 1'b1;
      win1     <= 1'b0;
      last1    <= 1'b0;
    end else begin
      if (frame_end0) begin
        o_raddr  <= '0;
        addr_cnt <= '0;
      end else if (win0) begin
        o_raddr  <= addr_cnt;
        addr_cnt <= addr_cnt + 1'b1;
      end
      act1  <= act0;
      hs1   <= hs0;
      vs1   <= vs0;
      win1  <= win0;
      last1 <= last0;
    end
  end

  // Stage 2: flags line up with the framebuffer read data
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      act2  <= 1'b0;
      hs2   <= 1'b1;
      vs2   <= 1'b1;
      win2  <= 1'b0;
      last2 <= 1'b0;
    end else begin
      act2  <= act1;
      hs2   <= hs1;
      vs2   <= vs1;
      win2  <= win1;
      last2 <= last1;
    end
  end

  // Threshold compare on the returning pixel; thresholds are used live
  logic match2, hit2;
  assign match2 = (i_rdata[R_MSB:R_LSB] >= i_r_min) &&
                  (i_rdata[G_MSB:G_LSB] <= i_g_max) &&
                  (i_rdata[B_MSB:B_LSB] <= i_b_max);
  assign hit2   = win2 && match2 && i_detect_en;

  // Saturating increment of the running count for this pixel
  logic [CW-1:0] run_cnt, cnt_next;
  always_comb begin
    cnt_next = run_cnt;
    if (hit2 && (run_cnt != CNT_MAX)) cnt_next = run_cnt + 1'b1;
  end

  // Stage 3: registered video out, plus frame-end count handoff on the last window pixel
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_de          <= 1'b0;
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_rgb         <= '0;
      run_cnt       <= '0;
      o_match_count <= '0;
      o_frame_done  <= 1'b0;
    end else begin
      o_de    <= act2;
      o_hsync <= hs2;
      o_vsync <= vs2;
      if (!win2)
        o_rgb <= '0;
      else if (hit2 && i_highlight)
        o_rgb <= HIGHLIGHT;
      else
        o_rgb <= i_rdata;
      if (last2) begin
        o_match_count <= cnt_next;
        run_cnt       <= '0;
        o_frame_done  <= 1'b1;
      end else begin
        run_cnt       <= cnt_next;
        o_frame_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fbuf_display_reader.sv
// Self-checking bench for fbuf_display_reader using a shrunken raster.
// Expected video/count come from a position-based model computed from the cycle index.
// BRAM model returns mem[o_raddr] one clock later.
module tb_fbuf_display_reader;

  localparam int FW = 8, FH = 6, DEPTH = FW * FH;
  localparam int HA = 12, HFP = 2, HSW = 3, HBP = 2;
  localparam int VA = 8, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam logic [15:0] HL = 16'h07E0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  raddr;
  logic [15:0] rdata = 16'h0;
  logic        detect_en = 1'b0, highlight = 1'b0;
  logic [4:0]  r_min = 5'd0, b_max = 5'd0;
  logic [5:0]  g_max = 6'd0;
  logic        hsync, vsync, de, fdone;
  logic [15:0] rgb;
  logic [5:0]  mcount;

  logic [15:0] mem [0:63];
  int cyc = 0;
  int vectors = 0;
  int errors = 0;

  fbuf_display_reader #(
    .DATA_WIDTH(16), .FRAME_W(FW), .FRAME_H(FH), .BRAM_DEPTH(DEPTH),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HIGHLIGHT(HL)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .o_raddr(raddr), .i_rdata(rdata),
    .i_detect_en(detect_en), .i_highlight(highlight),
    .i_r_min(r_min), .i_g_max(g_max), .i_b_max(b_max),
    .o_hsync(hsync), .o_vsync(vsync), .o_de(de), .o_rgb(rgb),
    .o_match_count(mcount), .o_frame_done(fdone)
  );

  always #20 clk = ~clk;

  // Synchronous-read framebuffer
  always @(posedge clk) rdata <= mem[raddr];

  // Clocks since reset release; the DUT raster sits at position cyc during that cycle
  always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

  // ---------------- reference model ----------------
  function automatic bit is_match(logic [15:0] d);
    return (d[15:11] >= r_min) && (d[10:5] <= g_max) && (d[4:0] <= b_max);
  endfunction

  // {hsync, vsync, de, rgb} expected on the outputs during cycle n
  function automatic logic [18:0] exp_vec(int n);
    int p, h, v;
    logic [15:0] px;
    if (n < 3) return {1'b1, 1'b1, 1'b0, 16'h0};
    p = (n - 3) % FT;
    h = p % HT;
    v = p / HT;
    px = 16'h0;
    if (h < FW && v < FH) begin
      px = mem[v * FW + h];
      if (detect_en && highlight && is_match(px)) px = HL;
    end
    return {!(h >= HA + HFP && h < HA + HFP + HSW),
            !(v >= VA + VFP && v < VA + VFP + VSW),
            (h < HA && v < VA), px};
  endfunction

  function automatic bit exp_done(int n);
    if (n < 3) return 1'b0;
    return ((n - 3) % FT) == (FH - 1) * HT + (FW - 1);
  endfunction

  function automatic int exp_count();
    int s = 0;
    if (!detect_en) return 0;
    for (int a = 0; a < DEPTH; a++) if (is_match(mem[a])) s++;
    return s;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int first_de = -1;
    for (int a = 0; a < 64; a++) mem[a] = 16'(a);
    detect_en = 1'b0; highlight = 1'b0;
    r_min = 5'd16; g_max = 6'd8; b_max = 5'd8;
    rstn = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++; if (hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync got %b want 1", hsync); end
    vectors++; if (vsync !== 1'b1) begin errors++; $display("FAIL rst_vsync got %b want 1", vsync); end
    vectors++; if (de !== 1'b0) begin errors++; $display("FAIL rst_de got %b want 0", de); end
    vectors++; if (rgb !== 16'h0) begin errors++; $display("FAIL rst_rgb got %h want 0", rgb); end
    vectors++; if (raddr !== 6'd0) begin errors++; $display("FAIL rst_raddr got %0d want 0", raddr); end
    vectors++; if (mcount !== 6'd0) begin errors++; $display("FAIL rst_count got %0d want 0", mcount); end
    vectors++; if (fdone !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", fdone); end
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (de === 1'b1 && first_de < 0) first_de = cyc;
      vectors++;
      if ({hsync, vsync, de, rgb} !== exp_vec(cyc)) begin
        errors++; $display("FAIL rst_release_video cyc=%0d got %h want %h", cyc, {hsync, vsync, de, rgb}, exp_vec(cyc));
      end
    end
    vectors++; if (first_de !== 3) begin errors++; $display("FAIL first_de_clk got %0d want 3", first_de); end
  endtask

  task automatic test_timing();
    int n_de = 0, n_hs = 0, n_vs = 0;
    for (int i = 0; i < FT; i++) begin
      @(negedge clk);
      if (de === 1'b1) n_de++;
      if (hsync === 1'b0) n_hs++;
      if (vsync === 1'b0) n_vs++;
      vectors++;
      if ({hsync, vsync, de, rgb} !== exp_vec(cyc)) begin
        errors++; $display("FAIL timing_video cyc=%0d got %h want %h", cyc, {hsync, vsync, de, rgb}, exp_vec(cyc));
      end
      vectors++;
      if (fdone !== exp_done(cyc)) begin errors++; $display("FAIL timing_done cyc=%0d got %b want %b", cyc, fdone, exp_done(cyc)); end
    end
    vectors++; if (n_de != HA * VA) begin errors++; $display("FAIL de_clks_per_frame got %0d want %0d", n_de, HA * VA); end
    vectors++; if (n_hs != HSW * VT) begin errors++; $display("FAIL hsync_low_clks got %0d want %0d", n_hs, HSW * VT); end
    vectors++; if (n_vs != VSW * HT) begin errors++; $display("FAIL vsync_low_clks got %0d want %0d", n_vs, VSW * HT); end
  endtask

  task automatic test_addressing();
    int seen = 0, p;
    for (int i = 0; i < 2 * FT + 10 && seen < 2; i++) begin
      @(negedge clk);
      p = (cyc - 1) % FT;
      if (cyc >= 1 && (p % HT) < FW && (p / HT) < FH) begin
        vectors++;
        if (raddr !== 6'((p / HT) * FW + (p % HT))) begin
          errors++; $display("FAIL raddr cyc=%0d got %0d want %0d", cyc, raddr, (p / HT) * FW + (p % HT));
        end
      end
      vectors++;
      if ({hsync, vsync, de, rgb} !== exp_vec(cyc)) begin
        errors++; $display("FAIL addr_video cyc=%0d got %h want %h", cyc, {hsync, vsync, de, rgb}, exp_vec(cyc));
      end
      if (fdone === 1'b1) seen++;
    end
    vectors++; if (seen != 2) begin errors++; $display("FAIL addr_frames got %0d want 2", seen); end
  endtask

  // Runs until one frame_done, checking video, pulse timing and count
  task automatic test_frame(input string tag, input int want_count);
    int seen = 0;
    for (int i = 0; i < FT + 10 && seen < 1; i++) begin
      @(negedge clk);
      vectors++;
      if ({hsync, vsync, de, rgb} !== exp_vec(cyc)) begin
        errors++; $display("FAIL %s_video cyc=%0d got %h want %h", tag, cyc, {hsync, vsync, de, rgb}, exp_vec(cyc));
      end
      vectors++;
      if (fdone !== exp_done(cyc)) begin errors++; $display("FAIL %s_done cyc=%0d got %b want %b", tag, cyc, fdone, exp_done(cyc)); end
      if (fdone === 1'b1) begin
        seen++;
        vectors++;
        if (mcount !== 6'(want_count)) begin errors++; $display("FAIL %s_count got %0d want %0d", tag, mcount, want_count); end
      end
    end
    vectors++; if (seen != 1) begin errors++; $display("FAIL %s_no_frame_done", tag); end
  endtask

  task automatic test_detect();
    for (int a = 0; a < 64; a++) mem[a] = 16'hF800;
    r_min = 5'd16; g_max = 6'd8; b_max = 5'd8;
    detect_en = 1'b1; highlight = 1'b0;
    test_frame("detect", DEPTH);
    highlight = 1'b1;
    test_frame("highlight", DEPTH);
  endtask

  task automatic test_mixed();
    for (int a = 0; a < 64; a++) mem[a] = (a % 2 == 0) ? 16'hF800 : 16'h001F;
    detect_en = 1'b1; highlight = 1'b1;
    test_frame("mixed", DEPTH / 2);
    detect_en = 1'b0;
    test_frame("disabled", 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      for (int a = 0; a < 64; a++) mem[a] = 16'($urandom);
      r_min = 5'($urandom); g_max = 6'($urandom); b_max = 5'($urandom);
      detect_en = ($urandom_range(0, 3) != 0);
      highlight = 1'($urandom);
      test_frame("random", exp_count());
    end
  endtask

  task automatic test_mid_reset();
    for (int a = 0; a < 64; a++) mem[a] = (a % 2 == 0) ? 16'hF800 : 16'h001F;
    r_min = 5'd16; g_max = 6'd8; b_max = 5'd8;
    detect_en = 1'b1; highlight = 1'b0;
    for (int i = 0; i < FT && ((cyc % FT) / HT) != 3; i++) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    vectors++; if (raddr !== 6'd0) begin errors++; $display("FAIL midrst_raddr got %0d want 0", raddr); end
    vectors++; if (de !== 1'b0) begin errors++; $display("FAIL midrst_de got %b want 0", de); end
    vectors++; if (mcount !== 6'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", mcount); end
    rstn = 1'b1;
    test_frame("after_reset", DEPTH / 2);
  endtask

  initial begin
    test_reset();
    test_timing();
    test_addressing();
    test_detect();
    test_mixed();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
